// File: rtl/knight_sprite_addr_gen_if.sv
// Scan-side bundle for the knight sprite address generator: VGA scan
// position, knight placement/animation controls in, sprite ROM
// addressing out. The address generator is the slave; the scan/game
// logic that drives it is the master.
interface knight_sprite_addr_gen_if;
    logic       vsync;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic [9:0] knight_x;
    logic [9:0] knight_y;
    logic       facing_left;
    logic       walking;
    logic [11:0] rom_address;
    logic [1:0]  frame_sel;
    logic        in_sprite;
    logic        blank_d;

    modport master (
        output vsync, DrawX, DrawY, blank, knight_x, knight_y, facing_left, walking,
        input  rom_address, frame_sel, in_sprite, blank_d
    );

    modport slave (
        input  vsync, DrawX, DrawY, blank, knight_x, knight_y, facing_left, walking,
        output rom_address, frame_sel, in_sprite, blank_d
    );
endinterface

// File: rtl/knight_sprite_addr_gen.sv
// Knight sprite address generator. Latches the knight position/facing on
// each vsync falling edge so a frame never tears, advances the walk
// animation every FRAME_DIV frames, and turns the scan coordinates into a
// per-pixel sprite ROM address through a two-stage pipeline.
module knight_sprite_addr_gen #(
    parameter int SPR_W      = 50,
    parameter int SPR_H      = 64,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_DIV  = 6
) (
    input  logic                   vga_clk,
    input  logic                   reset_n,
    knight_sprite_addr_gen_if.slave bus
);
    localparam int ADDR_W = 12;
    localparam int FSEL_W = 2;
    localparam int COL_W  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int ROW_W  = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int TICK_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    // Frame boundary detection and latched (tear-free) placement
    logic              vs_q;
    logic              frame_tick;
    logic [9:0]        lx;
    logic [9:0]        ly;
    logic              lf;
    logic [TICK_W-1:0] tick;
    logic [FSEL_W-1:0] frame_sel_q;

    // Pipeline stage 1
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic              hit1;
    logic              blank1;

    // Hit test is done at 11 bits so a sprite near the right/bottom edge
    // is clipped rather than wrapping around to column/row 0.
    logic [10:0]       x_end;
    logic [10:0]       y_end;
    logic              hit;
    logic [COL_W-1:0]  col_fwd;
    logic [COL_W-1:0]  col_next;

    assign frame_tick = vs_q & ~bus.vsync;
    assign x_end      = {1'b0, lx} + 11'(SPR_W);
    assign y_end      = {1'b0, ly} + 11'(SPR_H);
    assign hit        = (bus.DrawX >= lx) && ({1'b0, bus.DrawX} < x_end) &&
                        (bus.DrawY >= ly) && ({1'b0, bus.DrawY} < y_end);
    // Column offsets only matter on a hit, where they are < SPR_W and the
    // truncation to COL_W bits is lossless.
    assign col_fwd    = COL_W'(bus.DrawX - lx);
    assign col_next   = lf ? (COL_W'(SPR_W - 1) - col_fwd) : col_fwd;

    // Frame-boundary state: vsync edge register, latched placement and
    // the walk-animation divider/frame counter.
    // NOTE: every flop here uses <= so all of them see the pre-edge values
    // of each other; a blocking = would let frame_tick logic read updates
    // made earlier in the same edge.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_q        <= 1'b1;
            lx          <= '0;
            ly          <= '0;
            lf          <= 1'b0;
            tick        <= '0;
            frame_sel_q <= '0;
        end else begin
            vs_q <= bus.vsync;
            if (frame_tick) begin
                lx <= bus.knight_x;
                ly <= bus.knight_y;
                lf <= bus.facing_left;
                if (!bus.walking) begin
                    tick        <= '0;
                    frame_sel_q <= '0;
                end else if (tick == TICK_W'(FRAME_DIV - 1)) begin
                    tick        <= '0;
                    frame_sel_q <= (frame_sel_q == FSEL_W'(NUM_FRAMES - 1)) ?
                                   '0 : frame_sel_q + 1'b1;
                end else begin
                    tick <= tick + 1'b1;
                end
            end
        end
    end

    // Stage 1: sprite-relative row/column, hit flag and blank alignment.
    // NOTE: the pipeline registers are reset too; they are few flops and
    // this keeps in_sprite/blank_d from showing stale data after reset.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q  <= '0;
            row_q  <= '0;
            hit1   <= 1'b0;
            blank1 <= 1'b0;
        end else begin
            col_q  <= col_next;
            row_q  <= ROW_W'(bus.DrawY - ly);
            hit1   <= hit;
            blank1 <= bus.blank;
        end
    end

    // Stage 2: linear ROM address (zero outside the sprite box).
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rom_address <= '0;
            bus.in_sprite   <= 1'b0;
            bus.blank_d     <= 1'b0;
        end else begin
            bus.rom_address <= hit1 ? (ADDR_W'(row_q) * ADDR_W'(SPR_W) + ADDR_W'(col_q)) : '0;
            bus.in_sprite   <= hit1;
            bus.blank_d     <= blank1;
        end
    end

    assign bus.frame_sel = frame_sel_q;
endmodule

// File: tb/tb_knight_sprite_addr_gen.sv
// Testbench for knight_sprite_addr_gen: scoreboard of expected pixel
// responses computed from a plain-arithmetic model of the sprite box,
// checked by an independent monitor two clocks after each pixel is driven.
module tb_knight_sprite_addr_gen;
    localparam int SPR_W      = 50;
    localparam int SPR_H      = 64;
    localparam int NUM_FRAMES = 4;
    localparam int FRAME_DIV  = 6;

    logic vga_clk;
    logic reset_n;
    knight_sprite_addr_gen_if bus ();

    knight_sprite_addr_gen #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(NUM_FRAMES), .FRAME_DIV(FRAME_DIV)
    ) dut (
        .vga_clk(vga_clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int due;
        int addr;
        int ins;
        int bl;
        int fsel;
    } exp_t;
    exp_t sb[$];

    int m_lx = 0, m_ly = 0, m_lf = 0;
    int m_walk_frames = 0;   // consecutive walking frame boundaries

    function automatic int model_fsel();
        return (m_walk_frames / FRAME_DIV) % NUM_FRAMES;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic pix(input int x, input int y, input int b);
        exp_t e;
        int col;
        @(negedge vga_clk);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        bus.blank = b[0];
        e.due  = cyc + 2;
        e.bl   = b;
        e.fsel = model_fsel();
        if (x >= m_lx && x < m_lx + SPR_W && y >= m_ly && y < m_ly + SPR_H) begin
            col    = m_lf ? (SPR_W - 1 - (x - m_lx)) : (x - m_lx);
            e.addr = (y - m_ly) * SPR_W + col;
            e.ins  = 1;
        end else begin
            e.addr = 0;
            e.ins  = 0;
        end
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge vga_clk);
            bus.blank = 1'b0;
        end
    endtask

    // One vsync low pulse of len cycles presenting new placement/walking.
    task automatic vs_pulse(input int nx, input int ny, input int nf, input int w, input int len);
        idle(3);
        @(negedge vga_clk);
        bus.knight_x    = 10'(nx);
        bus.knight_y    = 10'(ny);
        bus.facing_left = nf[0];
        bus.walking     = w[0];
        bus.vsync       = 1'b0;
        m_lx = nx; m_ly = ny; m_lf = nf;
        if (w != 0) m_walk_frames++;
        else        m_walk_frames = 0;
        repeat (len - 1) @(negedge vga_clk);
        @(negedge vga_clk);
        bus.vsync = 1'b1;
        idle(1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge vga_clk);
            n++;
        end
        if (sb.size() > 0) check("drain", sb.size(), 0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge vga_clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check("due_cycle", cyc, e.due);
                check("rom_address", int'(bus.rom_address), e.addr);
                check("in_sprite", int'(bus.in_sprite), e.ins);
                check("blank_d", int'(bus.blank_d), e.bl);
                check("frame_sel", int'(bus.frame_sel), e.fsel);
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        bus.vsync       = 1'b1;
        bus.DrawX       = 10'd100;
        bus.DrawY       = 10'd0;
        bus.blank       = 1'b1;
        bus.knight_x    = '0;
        bus.knight_y    = '0;
        bus.facing_left = 1'b0;
        bus.walking     = 1'b0;
        reset_n         = 1'b0;
        repeat (3) @(negedge vga_clk);
        check("rst_rom_address", int'(bus.rom_address), 0);
        check("rst_in_sprite", int'(bus.in_sprite), 0);
        check("rst_blank_d", int'(bus.blank_d), 0);
        check("rst_frame_sel", int'(bus.frame_sel), 0);
        reset_n = 1'b1;

        // Basic addressing at (100,200)
        vs_pulse(100, 200, 0, 0, 2);
        pix(100, 200, 1);
        pix(149, 263, 1);
        pix(150, 263, 1);
        pix(99, 200, 0);
        pix(100, 264, 1);

        // Tear-free: live knight_x moves mid-frame, latched lx stays 100
        @(negedge vga_clk);
        bus.knight_x = 10'd300;
        pix(120, 210, 1);
        pix(149, 230, 1);
        pix(300, 210, 1);
        vs_pulse(300, 200, 0, 0, 2);
        pix(120, 210, 1);
        pix(300, 210, 1);
        pix(349, 263, 1);

        // Mirror
        vs_pulse(100, 200, 1, 0, 2);
        pix(100, 201, 1);
        pix(149, 201, 1);
        pix(125, 230, 0);

        // Right/bottom edge clipping, no wrap
        vs_pulse(1000, 200, 0, 0, 2);
        pix(1023, 200, 1);
        pix(999, 200, 1);
        for (int x = 0; x < 50; x += 7) pix(x, 210, 1);
        vs_pulse(500, 1000, 0, 0, 2);
        pix(510, 1023, 1);
        pix(510, 5, 1);

        // Randomized placements and pixels around the sprite
        for (int r = 0; r < 6; r++) begin
            int nx, ny;
            nx = $urandom_range(0, 1023);
            ny = $urandom_range(0, 1023);
            vs_pulse(nx, ny, $urandom_range(0, 1), 0, 2);
            for (int i = 0; i < 30; i++) begin
                int x, y;
                if ($urandom_range(0, 3) == 0) begin
                    x = $urandom_range(0, 1023);
                    y = $urandom_range(0, 1023);
                end else begin
                    x = (nx + $urandom_range(0, 69) + 1014) % 1024;
                    y = (ny + $urandom_range(0, 83) + 1014) % 1024;
                end
                pix(x, y, $urandom_range(0, 1));
            end
        end
        drain();

        // Animation: 24 walking frames, one pixel checked after each
        for (int p = 1; p <= 24; p++) begin
            vs_pulse(100, 200, 0, 1, 2);
            pix(110, 210, 1);
        end
        drain();
        for (int p = 1; p <= 8; p++) begin
            vs_pulse(100, 200, 0, 1, 2);
            pix(110, 210, 1);
        end
        // Walking dropped: frame_sel stays until the next frame boundary
        @(negedge vga_clk);
        bus.walking = 1'b0;
        pix(110, 210, 1);
        vs_pulse(100, 200, 0, 0, 2);
        pix(110, 210, 1);

        // vsync held low a long time counts as a single frame boundary
        for (int p = 1; p <= 5; p++) vs_pulse(100, 200, 0, 1, 2);
        vs_pulse(100, 200, 0, 1, 12);
        pix(110, 210, 1);
        vs_pulse(100, 200, 0, 1, 2);
        pix(110, 210, 1);
        drain();

        // Reset mid-frame: outputs clear and latched placement returns to 0
        @(negedge vga_clk);
        bus.DrawX = 10'd110;
        bus.DrawY = 10'd210;
        bus.blank = 1'b1;
        @(negedge vga_clk);
        reset_n = 1'b0;
        #1;
        check("midrst_rom_address", int'(bus.rom_address), 0);
        check("midrst_in_sprite", int'(bus.in_sprite), 0);
        check("midrst_blank_d", int'(bus.blank_d), 0);
        check("midrst_frame_sel", int'(bus.frame_sel), 0);
        @(negedge vga_clk);
        reset_n = 1'b1;
        m_lx = 0; m_ly = 0; m_lf = 0; m_walk_frames = 0;
        pix(10, 10, 1);
        pix(60, 10, 0);
        vs_pulse(200, 300, 0, 0, 2);
        pix(210, 310, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/knight_sprite_addr_gen.md
Name: knight_sprite_addr_gen

Overview:
- Upstream feeder for the knight sprite ROM/palette path.
- Takes VGA scan coordinates plus the knight's screen position and facing, and produces a per-pixel 50x64 sprite ROM address, a walk-animation frame select and an in-sprite flag.
- Advances the walk animation once every FRAME_DIV frames.
- Latches position and facing at frame boundaries so that no frame tears.

Parameters:
- SPR_W, 50, sprite width in pixels
- SPR_H, 64, sprite height in pixels
- NUM_FRAMES, 4, walk animation frames (frame_sel wraps at NUM_FRAMES-1)
- FRAME_DIV, 6, vsync frames per animation step (>=1)

Ports:
- vga_clk  in  1  pixel clock; all state on posedge
- reset_n  in  1  asynchronous, active-low reset
- vsync  in  1  VGA vsync, active-low pulse; frame boundary = registered falling edge
- DrawX  in  10  current scan column
- DrawY  in  10  current scan row
- blank  in  1  1 = visible region
- knight_x  in  10  sprite top-left column (live, sampled at frame boundary)
- knight_y  in  10  sprite top-left row (live, sampled at frame boundary)
- facing_left  in  1  1 = mirror sprite horizontally
- walking  in  1  1 = animate; 0 = hold idle frame 0
- rom_address  out  12  row*SPR_W + col into the per-frame ROM
- frame_sel  out  2  active walk frame for the downstream ROM mux
- in_sprite  out  1  current pipelined pixel lies inside the sprite box
- blank_d  out  1  blank delayed to align with rom_address

Behaviour:
- Reset (async, reset_n=0): rom_address=0, frame_sel=0, in_sprite=0, blank_d=0, tick counter=0, latched x/y/facing=0, vsync edge register=1.
- Frame boundary: vs_q <= vsync each cycle; frame_tick = vs_q & ~vsync (one cycle).
- On frame_tick:
  - latch knight_x, knight_y and facing_left into lx, ly, lf.
  - if walking=0: tick=0, frame_sel=0.
  - else if tick==FRAME_DIV-1: tick=0, frame_sel = (frame_sel==NUM_FRAMES-1) ? 0 : frame_sel+1.
  - else tick++.
- Addressing uses lx/ly/lf only, never the live inputs.
- Hit test uses 11-bit arithmetic:
  - hit = DrawX>=lx && DrawX<lx+SPR_W && DrawY>=ly && DrawY<ly+SPR_H.
  - No wrap when lx+SPR_W>1023; a partial sprite at the right or bottom edge is clipped, not wrapped.
- Stage 1 (posedge): col = DrawX-lx, row = DrawY-ly, hit1 = hit, blank1 = blank.
  - If lf=1, col = SPR_W-1-(DrawX-lx).
- Stage 2 (posedge): rom_address = hit1 ? row*SPR_W+col : 0; in_sprite = hit1; blank_d = blank1.
- Latency is exactly 2 vga_clk from DrawX/DrawY/blank to rom_address/in_sprite/blank_d.
- Max address = SPR_W*SPR_H-1 = 3199; it fits in 12 bits.
- frame_sel changes only on the frame_tick cycle, which falls in vertical blanking. It never changes mid-visible-frame.
- walking deasserted mid-animation: frame_sel returns to 0 at the next frame_tick, not immediately.
- vsync held low continuously: only one frame_tick.
- Reset mid-frame: outputs clear immediately. The first frame_tick after release latches position.

Test Plan:
- Reset: reset_n=0 with DrawX=100 -> all outputs 0. Release, pulse vsync with knight_x=100, knight_y=200, facing_left=0; drive DrawX=100, DrawY=200 -> 2 cycles later rom_address=0, in_sprite=1.
- Addressing with lx=100, ly=200: DrawX=149, DrawY=263 -> rom_address=3199, in_sprite=1. DrawX=150 -> in_sprite=0, rom_address=0.
- Mirror: facing_left=1 latched at vsync; DrawX=100, DrawY=201 -> rom_address=50+49=99. DrawX=149 -> rom_address=50.
- Animation: walking=1, FRAME_DIV=6; 24 vsync pulses -> frame_sel steps 1,2,3,0 on pulses 6,12,18,24. Drop walking after pulse 8 -> frame_sel=0 at pulse 9.
- Tear-free latching: change knight_x from 100 to 300 mid-frame -> addressing keeps lx=100 until the next vsync falling edge, then uses 300.
- Edge clip: knight_x=1000 latched; DrawX=1023 -> in_sprite=1, rom_address col=23. DrawX=0..49 -> in_sprite=0 (no wrap).
